memcpy_regs: RTL



---
 rtl/memcpy_regs.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/memcpy_regs.sv
// memcpy_regs: slave-lite control/status registers for the memcpy engine.
// Optional interrupt output (irq, CTRL.IE) is built when MEMCPY_REGS_IRQ_EN is defined.
module memcpy_regs #(
    parameter int DATA_WIDTH   = 32,
    parameter int S_ADDR_WIDTH = 12
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    s_awvalid,
    input  logic [S_ADDR_WIDTH-1:0] s_awaddr,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    input  logic                    s_arvalid,
    input  logic [S_ADDR_WIDTH-1:0] s_araddr,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic                    start,
    output logic [DATA_WIDTH-1:0]   size,
    output logic [DATA_WIDTH-1:0]   src_addr,
    output logic [DATA_WIDTH-1:0]   dst_addr,
    input  logic                    busy,
    input  logic                    done,
`ifdef MEMCPY_REGS_IRQ_EN
    output logic                    irq,
`endif
    input  logic [DATA_WIDTH-1:0]   result
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] IDX_CTRL   = 3'd0;
    localparam logic [2:0] IDX_SIZE   = 3'd1;
    localparam logic [2:0] IDX_SRC    = 3'd2;
    localparam logic [2:0] IDX_DST    = 3'd3;
    localparam logic [2:0] IDX_RESULT = 3'd4;
    localparam logic [2:0] IDX_CYCLES = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2
    } state_e;

    function automatic logic [2:0] addr_index(input logic [S_ADDR_WIDTH-1:0] addr);
        return addr[4:2];
    endfunction

    function automatic logic addr_in_range(input logic [S_ADDR_WIDTH-1:0] addr);
        return (addr[S_ADDR_WIDTH-1:5] == {(S_ADDR_WIDTH-5){1'b0}});
    endfunction

    function automatic logic [DATA_WIDTH-1:0] strobe_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_val;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

    state_e                state_q;
    logic                  awready_q, arready_q, wready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  start_q;
    logic [2:0]            widx_q;
    logic                  wrange_q;

    logic [DATA_WIDTH-1:0] size_q, size_d;
    logic [DATA_WIDTH-1:0] src_q, src_d;
    logic [DATA_WIDTH-1:0] dst_q, dst_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] cycles_q, cycles_d;
    logic                  done_sticky_q, done_sticky_d;
    logic                  ie_q, ie_d;
    logic                  irq_q, irq_d;

    logic                  wr_en_s;
    logic                  param_wr_s;
    logic                  start_acc_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    // A write lands only when the latched address was in range; job parameters
    // and launches are refused while the engine is running.
    assign wr_en_s     = (state_q == ST_WDATA) && wready_q && s_wvalid && wrange_q;
    assign param_wr_s  = wr_en_s && !busy;
    assign start_acc_s = wr_en_s && (widx_q == IDX_CTRL) && s_wdata[0] && !busy;

    // Next-state of the register file and status capture.
    always_comb begin
        size_d        = size_q;
        src_d         = src_q;
        dst_d         = dst_q;
        result_d      = result_q;
        cycles_d      = cycles_q;
        done_sticky_d = done_sticky_q;
        ie_d          = ie_q;

        if (param_wr_s && (widx_q == IDX_SIZE)) begin
            size_d = strobe_merge(size_q, s_wdata, s_wstrb);
        end else begin
            size_d = size_q;
        end
        if (param_wr_s && (widx_q == IDX_SRC)) begin
            src_d = strobe_merge(src_q, s_wdata, s_wstrb);
        end else begin
            src_d = src_q;
        end
        if (param_wr_s && (widx_q == IDX_DST)) begin
            dst_d = strobe_merge(dst_q, s_wdata, s_wstrb);
        end else begin
            dst_d = dst_q;
        end

        if (done) begin
            result_d = result;
        end else begin
            result_d = result_q;
        end

        // A launch in the same cycle as a completion pulse leaves the job "not done".
        if (start_acc_s) begin
            done_sticky_d = 1'b0;
            cycles_d      = {DATA_WIDTH{1'b0}};
        end else begin
            if (done) begin
                done_sticky_d = 1'b1;
            end else begin
                done_sticky_d = done_sticky_q;
            end
            if (busy && (cycles_q != {DATA_WIDTH{1'b1}})) begin
                cycles_d = cycles_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cycles_d = cycles_q;
            end
        end

`ifdef MEMCPY_REGS_IRQ_EN
        if (wr_en_s && (widx_q == IDX_CTRL)) begin
            ie_d = s_wdata[2];
        end else begin
            ie_d = ie_q;
        end
`else
        ie_d = 1'b0;
`endif
        // Uses the settled sticky bit so irq trails done_sticky by one cycle,
        // while a launch or IE=0 drops it immediately.
        irq_d = ie_d & done_sticky_q & done_sticky_d;
    end

    // Read mux; sampled into rdata_q at AR acceptance.
    always_comb begin
        rd_word_s = {DATA_WIDTH{1'b0}};
        if (addr_in_range(s_araddr)) begin
            case (addr_index(s_araddr))
                IDX_CTRL:   rd_word_s = {{(DATA_WIDTH-3){1'b0}}, ie_q, done_sticky_q, busy};
                IDX_SIZE:   rd_word_s = size_q;
                IDX_SRC:    rd_word_s = src_q;
                IDX_DST:    rd_word_s = dst_q;
                IDX_RESULT: rd_word_s = result_q;
                IDX_CYCLES: rd_word_s = cycles_q;
                default:    rd_word_s = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            rd_word_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Handshake FSM with registered ready/valid outputs, plus register file update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            awready_q     <= 1'b0;
            arready_q     <= 1'b0;
            wready_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= {DATA_WIDTH{1'b0}};
            start_q       <= 1'b0;
            widx_q        <= 3'd0;
            wrange_q      <= 1'b0;
            size_q        <= {DATA_WIDTH{1'b0}};
            src_q         <= {DATA_WIDTH{1'b0}};
            dst_q         <= {DATA_WIDTH{1'b0}};
            result_q      <= {DATA_WIDTH{1'b0}};
            cycles_q      <= {DATA_WIDTH{1'b0}};
            done_sticky_q <= 1'b0;
            ie_q          <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            size_q        <= size_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            result_q      <= result_d;
            cycles_q      <= cycles_d;
            done_sticky_q <= done_sticky_d;
            ie_q          <= ie_d;
            irq_q         <= irq_d;
            start_q       <= start_acc_s;

            case (state_q)
                ST_IDLE: begin
                    if (awready_q && s_awvalid) begin
                        widx_q    <= addr_index(s_awaddr);
                        wrange_q  <= addr_in_range(s_awaddr);
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= ST_WDATA;
                    end else if (arready_q && s_arvalid) begin
                        rdata_q   <= rd_word_s;
                        rvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        state_q   <= ST_RDATA;
                    end else begin
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    if (s_wvalid) begin
                        wready_q  <= 1'b0;
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q   <= ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (s_rready) begin
                        rvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q   <= ST_RDATA;
                    end
                end
                default: begin
                    awready_q <= 1'b0;
                    arready_q <= 1'b0;
                    wready_q  <= 1'b0;
                    rvalid_q  <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_awready = awready_q;
    assign s_arready = arready_q;
    assign s_wready  = wready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rdata   = rdata_q;
    assign start     = start_q;
    assign size      = size_q;
    assign src_addr  = src_q;
    assign dst_addr  = dst_q;
`ifdef MEMCPY_REGS_IRQ_EN
    assign irq       = irq_q;
`endif

endmodule
